// File: rtl/display_7s_pkg.sv
// Shared definitions for the 7-segment display path: digit geometry, blank code,
// FSM encoding and elaboration-time width helpers.
package display_7s_pkg;

  localparam int DIS_DIGITS  = 8;
  localparam int DIS_DIGIT_W = 10;

  // All segments and the decimal point off.
  localparam logic [DIS_DIGIT_W-1:0] DIS_BLANK = '0;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A terminal of 0 or 1 still needs a one-bit register.
  function automatic int cnt_width(input int term);
    return (clog2(term) < 1) ? 1 : clog2(term);
  endfunction

endpackage

// File: rtl/display_7s_tick_counter.sv
// Tick-driven up-counter that saturates at TERM-1 and flags that terminal value.
// Clear wins over enable; a TERM of 0 leaves the counter parked at zero.
module display_7s_tick_counter
  import display_7s_pkg::*;
#(
  parameter int TERM = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = cnt_width(TERM);
  localparam logic [W-1:0] LAST = (TERM > 0) ? W'(TERM - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/display_7s_mux_seq.sv
// Registered N-channel content selector for the 7-segment driver: manual or
// auto-rotating channel choice with an optional blank interval on each switch.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_SHOW  | selected channel drives dis_data; watch for a switch request
//   ST_BLANK | BLANK_VALUE drives dis_data until BLANK_TICKS ticks elapse
module display_7s_mux_seq
  import display_7s_pkg::*;
#(
  parameter int              CH          = 8,
  parameter int              DW          = DIS_DIGITS * DIS_DIGIT_W,
  parameter int              DWELL_TICKS = 1000,
  parameter int              BLANK_TICKS = 50,
  parameter logic [DW-1:0]   BLANK_VALUE = '0,
  localparam int             SELW        = clog2(CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CH*DW-1:0]  dis_content,
  input  logic [SELW-1:0]   sel_manual,
  input  logic              mode,
  input  logic              hold,
  input  logic              next,
  input  logic              tick,
  output logic [DW-1:0]     dis_data,
  output logic [SELW-1:0]   sel_active,
  output logic              blanking,
  output logic              switched
);

  state_t            state, state_d;
  logic [SELW-1:0]   sel_d;
  logic [SELW-1:0]   manual_target;
  logic [SELW-1:0]   auto_target;
  logic              req;
  logic              switched_d;
  logic              dwell_tc;
  logic              blank_tc;

  // Out-of-range manual requests fall back to channel 0.
  assign manual_target = (int'(sel_manual) < CH) ? sel_manual : '0;
  assign auto_target   = (sel_active == SELW'(CH - 1)) ? '0 : sel_active + 1'b1;

  // Held in clear while in manual mode, so entering auto always starts from zero.
  display_7s_tick_counter #(.TERM(DWELL_TICKS)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (req | ~mode),
    .en      ((state == ST_SHOW) & mode & ~hold & tick),
    .tc      (dwell_tc)
  );

  display_7s_tick_counter #(.TERM(BLANK_TICKS)) u_blank (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (req),
    .en      ((state == ST_BLANK) & tick),
    .tc      (blank_tc)
  );

  always_comb begin
    state_d    = state;
    sel_d      = sel_active;
    switched_d = 1'b0;
    req        = 1'b0;
    case (state)
      ST_SHOW: begin
        if (mode) begin
          // next and a terminal tick in the same cycle still advance only once
          req = next | (tick & ~hold & dwell_tc);
          if (req) sel_d = auto_target;
        end else begin
          req = (manual_target != sel_active);
          if (req) sel_d = manual_target;
        end
        if (req) begin
          if (BLANK_TICKS > 0) state_d = ST_BLANK;
          else switched_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (tick & blank_tc) begin
          state_d    = ST_SHOW;
          switched_d = 1'b1;
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_SHOW;
      sel_active <= '0;
      switched   <= 1'b0;
      dis_data   <= BLANK_VALUE;
    end else begin
      state      <= state_d;
      sel_active <= sel_d;
      switched   <= switched_d;
      dis_data   <= (state == ST_BLANK) ? BLANK_VALUE
                                        : dis_content[int'(sel_active)*DW +: DW];
    end
  end

  assign blanking = (state == ST_BLANK);

endmodule

// File: tb/tb_display_7s_mux_seq.sv
// Directed bench: main instance CH=4/DWELL=3/BLANK=2, second instance CH=3 without blanking.
module tb_display_7s_mux_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] content_a = 32'hA3A2A1A0;
  logic [23:0] content_b = 24'hA2A1A0;
  logic [1:0]  sel_a, sel_b;
  logic        mode_a, mode_b, hold, next_a, next_b, tick;
  logic [7:0]  dd_a, dd_b;
  logic [1:0]  sa_a, sa_b;
  logic        bl_a, bl_b, sw_a, sw_b;

  int errors = 0;
  int checks = 0;

  display_7s_mux_seq #(.CH(4), .DW(8), .DWELL_TICKS(3), .BLANK_TICKS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .dis_content(content_a), .sel_manual(sel_a),
    .mode(mode_a), .hold(hold), .next(next_a), .tick(tick),
    .dis_data(dd_a), .sel_active(sa_a), .blanking(bl_a), .switched(sw_a)
  );

  display_7s_mux_seq #(.CH(3), .DW(8), .DWELL_TICKS(3), .BLANK_TICKS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .dis_content(content_b), .sel_manual(sel_b),
    .mode(mode_b), .hold(hold), .next(next_b), .tick(tick),
    .dis_data(dd_b), .sel_active(sa_b), .blanking(bl_b), .switched(sw_b)
  );

  typedef struct {
    logic [1:0] sel;
    logic       mode, hold, next, tick;
    logic [7:0] dd;
    logic [1:0] sa;
    logic       bl, sw;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_a(input int idx, input logic [7:0] dd, input logic [1:0] sa, input logic bl, input logic sw);
    check("a_dis_data", idx, dd_a, dd);
    check("a_sel_active", idx, {6'd0, sa_a}, {6'd0, sa});
    check("a_blanking", idx, {7'd0, bl_a}, {7'd0, bl});
    check("a_switched", idx, {7'd0, sw_a}, {7'd0, sw});
  endtask

  task automatic step_b(input int idx, input logic [1:0] sel, input logic md, input logic nx,
                        input logic [7:0] dd, input logic [1:0] sa, input logic sw);
    sel_b = sel; mode_b = md; next_b = nx;
    @(posedge clk); #1;
    check("b_dis_data", idx, dd_b, dd);
    check("b_sel_active", idx, {6'd0, sa_b}, {6'd0, sa});
    check("b_blanking", idx, {7'd0, bl_b}, 8'd0);
    check("b_switched", idx, {7'd0, sw_b}, {7'd0, sw});
  endtask

  initial begin
    // sel, mode, hold, next, tick | dis_data, sel_active, blanking, switched
    vt.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 1'b0, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2, 2'd1, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1, 2'd1, 1'b0, 1'b0});
    // auto rotation with wrap 3 -> 0
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd3, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 2'd3, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 2'd3, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 2'd0, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0, 1'b0});
    // hold freezes dwell for 10 ticks
    for (int i = 0; i < 10; i++)
      vt.push_back('{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0, 1'b0});
    // next overrides hold; dwell restarts from zero afterwards
    vt.push_back('{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA0, 2'd1, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b1, 1'b0});
    // next ignored in blank; tick+next together advances once
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b0, 1'b1});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd3, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b0});
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1});
    // mode change mid-blank completes the pending channel, then manual takes over
    vt.push_back('{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA3, 2'd0, 1'b1, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1});
    vt.push_back('{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd2, 1'b1, 1'b0});

    reset_n = 1'b0;
    sel_a = 2'd0; mode_a = 1'b0; hold = 1'b0; next_a = 1'b0; tick = 1'b0;
    sel_b = 2'd0; mode_b = 1'b0; next_b = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_a(-1, 8'h00, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      sel_a = vt[i].sel; mode_a = vt[i].mode; hold = vt[i].hold;
      next_a = vt[i].next; tick = vt[i].tick;
      @(posedge clk); #1;
      check_a(i, vt[i].dd, vt[i].sa, vt[i].bl, vt[i].sw);
    end

    // async reset in the middle of a blank
    sel_a = 2'd0; mode_a = 1'b0; hold = 1'b0; next_a = 1'b0; tick = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_a(100, 8'h00, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_a(101, 8'hA0, 2'd0, 1'b0, 1'b0);

    // CH=3, no blanking: out-of-range select and 2 -> 0 wrap
    step_b(0, 2'd1, 1'b0, 1'b0, 8'hA0, 2'd1, 1'b1);
    step_b(1, 2'd1, 1'b0, 1'b0, 8'hA1, 2'd1, 1'b0);
    step_b(2, 2'd3, 1'b0, 1'b0, 8'hA1, 2'd0, 1'b1);
    step_b(3, 2'd3, 1'b0, 1'b0, 8'hA0, 2'd0, 1'b0);
    step_b(4, 2'd0, 1'b1, 1'b1, 8'hA0, 2'd1, 1'b1);
    step_b(5, 2'd0, 1'b1, 1'b0, 8'hA1, 2'd1, 1'b0);
    step_b(6, 2'd0, 1'b1, 1'b1, 8'hA1, 2'd2, 1'b1);
    step_b(7, 2'd0, 1'b1, 1'b1, 8'hA2, 2'd0, 1'b1);
    step_b(8, 2'd0, 1'b1, 1'b0, 8'hA0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
